// File: rtl/huffman_decoder.sv
// Serial Huffman bitstream decoder: loads a (symbol, length, code) table, then
// consumes one code bit per handshake and emits one symbol per matched codeword.
module huffman_decoder #(
    parameter int BIT_WIDTH = 8,
    parameter int NUM_ENT   = 16,
    parameter int MAX_LEN   = 8,
    parameter int TB_WIDTH  = 11
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         tbl_we_i,
    input  logic                         tbl_clr_i,
    input  logic [$clog2(NUM_ENT)-1:0]   tbl_idx_i,
    input  logic [BIT_WIDTH-1:0]         tbl_sym_i,
    input  logic [$clog2(MAX_LEN+1)-1:0] tbl_len_i,
    input  logic [MAX_LEN-1:0]           tbl_code_i,
    input  logic                         start_i,
    input  logic [TB_WIDTH-1:0]          total_bit_i,
    input  logic                         bit_valid_i,
    input  logic                         bit_i,
    output logic                         bit_ready_o,
    output logic                         char_valid_o,
    output logic [BIT_WIDTH-1:0]         char_o,
    input  logic                         char_ready_i,
    output logic                         busy_o,
    output logic                         done_de_o,
    output logic                         err_o,
    output logic [2:0]                   dbg_state_o
);
    localparam int LW = $clog2(MAX_LEN + 1);

    // Handshakes: a bit transfers on a rising edge where bit_valid_i && bit_ready_o;
    // a character transfers on a rising edge where char_valid_o && char_ready_i.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SHIFT = 3'd1,
        S_CHECK = 3'd2,
        S_EMIT  = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [NUM_ENT-1:0]     r_vld;
    logic [BIT_WIDTH-1:0]   r_sym  [NUM_ENT];
    logic [LW-1:0]          r_elen [NUM_ENT];
    logic [MAX_LEN-1:0]     r_code [NUM_ENT];
    logic [MAX_LEN-1:0]     r_acc;
    logic [LW-1:0]          r_len;
    logic [TB_WIDTH-1:0]    r_rem;
    logic [BIT_WIDTH-1:0]   r_char;
    logic [MAX_LEN-1:0]     w_mask;
    logic                   w_hit;
    logic [BIT_WIDTH-1:0]   w_hit_sym;
    logic                   w_busy;

    assign w_busy = (r_state == S_SHIFT) || (r_state == S_CHECK) || (r_state == S_EMIT);

    // Only the low r_len bits of the accumulator and of each code take part;
    // scanning from the top index down leaves the lowest hitting index in place.
    always_comb begin
        w_mask    = '0;
        w_hit     = 1'b0;
        w_hit_sym = '0;
        for (int b = 0; b < MAX_LEN; b++) begin
            w_mask[b] = (LW'(b) < r_len);
        end
        for (int i = NUM_ENT - 1; i >= 0; i--) begin
            if (r_vld[i] && (r_elen[i] == r_len) && (((r_code[i] ^ r_acc) & w_mask) == '0)) begin
                w_hit     = 1'b1;
                w_hit_sym = r_sym[i];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_i) w_next = (total_bit_i == '0) ? S_DONE : S_SHIFT;
            end
            S_SHIFT: begin
                if (bit_valid_i) w_next = S_CHECK;
            end
            S_CHECK: begin
                if (w_hit)                                         w_next = S_EMIT;
                else if ((r_len == LW'(MAX_LEN)) || (r_rem == '0)) w_next = S_ERR;
                else                                               w_next = S_SHIFT;
            end
            S_EMIT: begin
                if (char_ready_i) w_next = (r_rem == '0) ? S_DONE : S_SHIFT;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_vld <= '0;
            for (int i = 0; i < NUM_ENT; i++) begin
                r_sym[i]  <= '0;
                r_elen[i] <= '0;
                r_code[i] <= '0;
            end
        end else if (!w_busy) begin
            if (tbl_clr_i) begin
                r_vld <= '0;
            end else if (tbl_we_i) begin
                r_sym[tbl_idx_i]  <= tbl_sym_i;
                r_elen[tbl_idx_i] <= tbl_len_i;
                r_code[tbl_idx_i] <= tbl_code_i;
                r_vld[tbl_idx_i]  <= (tbl_len_i != '0);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_acc  <= '0;
            r_len  <= '0;
            r_rem  <= '0;
            r_char <= '0;
        end else begin
            if (start_i && !w_busy) begin
                r_rem <= total_bit_i;
                r_acc <= '0;
                r_len <= '0;
            end
            if ((r_state == S_SHIFT) && bit_valid_i) begin
                r_acc <= {r_acc[MAX_LEN-2:0], bit_i};
                r_len <= r_len + LW'(1);
                if (r_rem != '0) r_rem <= r_rem - TB_WIDTH'(1);
            end
            if ((r_state == S_CHECK) && w_hit) begin
                r_char <= w_hit_sym;
            end
            if ((r_state == S_EMIT) && char_ready_i) begin
                r_acc <= '0;
                r_len <= '0;
            end
        end
    end

    assign bit_ready_o  = (r_state == S_SHIFT);
    assign char_valid_o = (r_state == S_EMIT);
    assign char_o       = r_char;
    assign busy_o       = w_busy;
    assign done_de_o    = (r_state == S_DONE);
    assign err_o        = (r_state == S_ERR);
    assign dbg_state_o  = r_state;

endmodule

// File: tb/tb_huffman_decoder.sv
// Bench for huffman_decoder: directed scenarios plus random tables/streams,
// checked against a prefix-matching reference model of the code table.
module tb_huffman_decoder;
  localparam int BW = 8;
  localparam int NE = 16;
  localparam int ML = 8;
  localparam int TW = 11;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          tbl_we_i, tbl_clr_i;
  logic [3:0]    tbl_idx_i;
  logic [BW-1:0] tbl_sym_i;
  logic [3:0]    tbl_len_i;
  logic [ML-1:0] tbl_code_i;
  logic          start_i;
  logic [TW-1:0] total_bit_i;
  logic          bit_valid_i, bit_i, bit_ready_o;
  logic          char_valid_o, char_ready_i;
  logic [BW-1:0] char_o;
  logic          busy_o, done_de_o, err_o;
  logic [2:0]    dbg_state_o;

  huffman_decoder #(.BIT_WIDTH(BW), .NUM_ENT(NE), .MAX_LEN(ML), .TB_WIDTH(TW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .tbl_we_i(tbl_we_i), .tbl_clr_i(tbl_clr_i),
    .tbl_idx_i(tbl_idx_i), .tbl_sym_i(tbl_sym_i), .tbl_len_i(tbl_len_i),
    .tbl_code_i(tbl_code_i), .start_i(start_i), .total_bit_i(total_bit_i),
    .bit_valid_i(bit_valid_i), .bit_i(bit_i), .bit_ready_o(bit_ready_o),
    .char_valid_o(char_valid_o), .char_o(char_o), .char_ready_i(char_ready_i),
    .busy_o(busy_o), .done_de_o(done_de_o), .err_o(err_o), .dbg_state_o(dbg_state_o)
  );

  always #5 clk_i = ~clk_i;

  int            n_cmp = 0;
  int            n_fail = 0;
  bit            stim_q[$];
  logic [BW-1:0] exp_q[$];
  bit            exp_done, exp_err;
  int            exp_used;
  logic [BW-1:0] m_sym[NE];
  int            m_len[NE];
  logic [ML-1:0] m_code[NE];
  int            cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic model_clear();
    for (int e = 0; e < NE; e++) m_len[e] = 0;
  endtask

  task automatic tbl_write(input int idx, input logic [BW-1:0] sym, input int len, input logic [ML-1:0] code);
    tbl_we_i = 1'b1; tbl_idx_i = 4'(idx); tbl_sym_i = sym; tbl_len_i = 4'(len); tbl_code_i = code;
    tick();
    tbl_we_i = 1'b0;
    m_sym[idx] = sym; m_len[idx] = len; m_code[idx] = code;
  endtask

  task automatic tbl_clear();
    tbl_clr_i = 1'b1;
    tick();
    tbl_clr_i = 1'b0;
    model_clear();
  endtask

  task automatic load_abc();
    tbl_clear();
    tbl_write(0, 8'h41, 1, 8'h00);
    tbl_write(1, 8'h42, 2, 8'h02);
    tbl_write(2, 8'h43, 2, 8'h03);
  endtask

  // First transmitted bit is pat[n-1].
  task automatic set_bits(input logic [31:0] pat, input int n);
    stim_q.delete();
    for (int i = n - 1; i >= 0; i--) stim_q.push_back(pat[i]);
  endtask

  // Reference: grow a prefix bit by bit; the lowest valid entry whose
  // (length, code) equals the prefix wins. Failure when the prefix reaches
  // the maximum length or the stream runs out without a match.
  task automatic model_run(input int total);
    int val, l;
    bit hit;
    val = 0; l = 0;
    exp_q.delete(); exp_err = 0; exp_used = 0;
    for (int i = 0; i < total; i++) begin
      hit = 0;
      val = (val << 1) | int'(stim_q[i]);
      l++;
      exp_used++;
      for (int e = 0; e < NE; e++) begin
        if (!hit && m_len[e] != 0 && m_len[e] == l && ((int'(m_code[e]) & ((1 << l) - 1)) == val)) begin
          exp_q.push_back(m_sym[e]);
          hit = 1;
        end
      end
      if (hit) begin
        val = 0; l = 0;
      end else if (l == ML || i == total - 1) begin
        exp_err = 1;
        break;
      end
    end
    exp_done = !exp_err;
  endtask

  // stall_n < 0 picks a random stall per character; busy_wr tries a table
  // write and a table clear while the decoder is busy.
  task automatic decode(input int total, input int stall_n, input int gap_max, input bit busy_wr, output int cyc_o);
    int idx, stall, wr_step;
    bit fin, holding;
    logic [BW-1:0] held;
    model_run(total);
    start_i = 1'b1; total_bit_i = TW'(total);
    tick();
    start_i = 1'b0;
    idx = 0; cyc_o = 0; fin = 0; holding = 0; held = '0; wr_step = 0;
    stall = (stall_n < 0) ? int'($urandom_range(0, 3)) : stall_n;
    while (!fin && cyc_o < 3000) begin
      tbl_we_i = 1'b0; tbl_clr_i = 1'b0; bit_valid_i = 1'b0; char_ready_i = 1'b0;
      if (done_de_o || err_o) begin
        fin = 1;
      end else begin
        if (char_valid_o) begin
          check("ready_in_emit", bit_ready_o, 0);
          if (holding) check("char_stable", char_o, held);
          if (stall > 0) begin
            stall--; holding = 1; held = char_o;
          end else begin
            char_ready_i = 1'b1; holding = 0;
            check("char_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check("char", char_o, exp_q.pop_front());
            stall = (stall_n < 0) ? int'($urandom_range(0, 3)) : stall_n;
          end
        end else if (bit_ready_o) begin
          if (busy_wr && wr_step < 2) begin
            check("busy_during_write", busy_o, 1);
            if (wr_step == 0) begin
              tbl_we_i = 1'b1; tbl_idx_i = 4'd0; tbl_sym_i = 8'h5A; tbl_len_i = 4'd1; tbl_code_i = 8'h01;
            end else begin
              tbl_clr_i = 1'b1;
            end
            wr_step++;
          end else if (idx < total && $urandom_range(0, gap_max) == 0) begin
            bit_valid_i = 1'b1; bit_i = stim_q[idx];
            idx++;
          end
        end
        tick();
        cyc_o++;
      end
    end
    check("timeout", fin, 1);
    check("done", done_de_o, exp_done);
    check("err", err_o, exp_err);
    check("bits_used", idx, exp_used);
    check("chars_left", exp_q.size(), 0);
    check("busy_end", busy_o, 0);
    if (exp_err) begin
      bit_valid_i = 1'b1;
      repeat (3) begin
        tick();
        check("ready_after_err", bit_ready_o, 0);
      end
      check("err_held", err_o, 1);
      check("done_in_err", done_de_o, 0);
      bit_valid_i = 1'b0;
    end
  endtask

  initial begin
    rst_i = 1'b1; tbl_we_i = 0; tbl_clr_i = 0; tbl_idx_i = 0; tbl_sym_i = 0; tbl_len_i = 0;
    tbl_code_i = 0; start_i = 0; total_bit_i = 0; bit_valid_i = 0; bit_i = 0; char_ready_i = 0;
    model_clear();
    repeat (3) tick();
    check("rst_bit_ready", bit_ready_o, 0);
    check("rst_char_valid", char_valid_o, 0);
    check("rst_char", char_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_de_o, 0);
    check("rst_err", err_o, 0);
    rst_i = 1'b0;
    tick();

    // Basic stream: 0 | 10 | 0 | 11 -> A B A C
    load_abc();
    set_bits(32'b010011, 6);
    decode(6, 0, 0, 0, cyc);
    set_bits(32'b010011, 6);
    decode(6, 5, 0, 0, cyc);

    // Table writes while busy must be ignored
    set_bits(32'b0, 1);
    decode(1, 0, 0, 1, cyc);
    set_bits(32'b0100, 4);
    decode(4, 0, 1, 0, cyc);

    // Missing C: "11" never matches before the stream ends
    tbl_clear();
    tbl_write(0, 8'h41, 1, 8'h00);
    tbl_write(1, 8'h42, 2, 8'h02);
    set_bits(32'b11, 2);
    decode(2, 0, 0, 0, cyc);
    set_bits(32'b1, 1);
    decode(1, 0, 0, 0, cyc);

    // Eight unmatched bits hit the length limit before the stream ends
    tbl_clear();
    tbl_write(0, 8'h41, 1, 8'h00);
    set_bits(32'h3FF, 10);
    decode(10, 0, 0, 0, cyc);

    // Empty stream
    stim_q.delete();
    decode(0, 0, 0, 0, cyc);
    check("zero_latency", cyc <= 1, 1);

    // Reset asserted while a character is waiting
    load_abc();
    start_i = 1'b1; total_bit_i = 11'd6;
    tick();
    start_i = 1'b0; bit_valid_i = 1'b1; bit_i = 1'b0;
    for (int i = 0; i < 10 && !char_valid_o; i++) tick();
    bit_valid_i = 1'b0;
    check("reached_emit", char_valid_o, 1);
    rst_i = 1'b1;
    #1;
    check("arst_char_valid", char_valid_o, 0);
    check("arst_char", char_o, 0);
    check("arst_busy", busy_o, 0);
    check("arst_bit_ready", bit_ready_o, 0);
    check("arst_done", done_de_o, 0);
    check("arst_err", err_o, 0);
    tick();
    rst_i = 1'b0;
    model_clear();
    tick();
    set_bits(32'b0, 1);
    decode(1, 0, 0, 0, cyc);
    load_abc();
    set_bits(32'b1100010, 7);
    decode(7, -1, 2, 0, cyc);

    // Random tables and streams
    for (int t = 0; t < 24; t++) begin
      int total;
      if (t < 8) begin
        load_abc();
      end else begin
        tbl_clear();
        for (int e = 0; e < 6; e++) begin
          tbl_write(int'($urandom_range(0, NE - 1)), 8'($urandom), int'($urandom_range(0, 4)), 8'($urandom));
        end
      end
      total = int'($urandom_range(0, 30));
      stim_q.delete();
      for (int i = 0; i < total; i++) stim_q.push_back(1'($urandom_range(0, 1)));
      decode(total, -1, 2, 0, cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/huffman_decoder.md
Name: huffman_decoder

Overview:
Serial Huffman bitstream decoder. It is the receive-side counterpart of the team's Huffman encoder. A code table of (symbol, length, code) entries is loaded first. The block then consumes a stream of total_bit_i code bits, one bit per handshake, and emits one decoded character per matched codeword on a valid/ready output. It flags completion or a malformed stream.

Parameters:
BIT_WIDTH, 8, symbol width
NUM_ENT, 16, code table entries
MAX_LEN, 8, maximum codeword length in bits
TB_WIDTH, 11, width of total bit count

Ports:
clk_i  input  1  clock
rst_i  input  1  reset, asynchronous, active-high
tbl_we_i  input  1  table write strobe
tbl_clr_i  input  1  clear all table valid bits
tbl_idx_i  input  $clog2(NUM_ENT)  table entry index
tbl_sym_i  input  BIT_WIDTH  symbol for entry
tbl_len_i  input  $clog2(MAX_LEN+1)  code length; 0 = entry invalid
tbl_code_i  input  MAX_LEN  code, right-aligned; bit [len-1] is the first transmitted bit
start_i  input  1  start pulse; latches total_bit_i
total_bit_i  input  TB_WIDTH  number of code bits in the stream
bit_valid_i  input  1  input bit valid
bit_i  input  1  input code bit
bit_ready_o  output  1  decoder accepts a bit
char_valid_o  output  1  decoded character valid
char_o  output  BIT_WIDTH  decoded character
char_ready_i  input  1  downstream accepts character
busy_o  output  1  decode in progress
done_de_o  output  1  stream fully decoded
err_o  output  1  malformed stream

Behaviour:
- Reset (asynchronous, any state): all outputs 0, FSM to IDLE, all table valid bits cleared, accumulator/length/count cleared.
- Table writes:
  - Accepted only when busy_o=0. Ignored when busy.
  - tbl_we_i writes {sym,len,code} at tbl_idx_i; entry is valid iff len!=0.
  - tbl_clr_i has priority over tbl_we_i in the same cycle.
- FSM states: IDLE, SHIFT, CHECK, EMIT, DONE, ERR.
- IDLE/DONE/ERR, on start_i:
  - Latch total_bit_i into remaining count; clear acc and len; clear done_de_o and err_o.
  - If total_bit_i=0: go to DONE, with done_de_o=1 on the next cycle.
  - Otherwise go to SHIFT.
  - start_i in SHIFT/CHECK/EMIT is ignored.
- SHIFT:
  - bit_ready_o=1 in this state only.
  - On bit_valid_i&bit_ready_o: acc={acc[MAX_LEN-2:0],bit_i}, len+1, remaining-1, then go to CHECK.
  - No bit: stay in SHIFT.
- CHECK: compare acc[len-1:0] and len against every valid entry in parallel.
  - Hit: latch the symbol into char_o, go to EMIT. If several entries hit, the lowest index wins.
  - Miss and (len==MAX_LEN or remaining==0): go to ERR.
  - Miss otherwise: go to SHIFT.
- EMIT:
  - char_valid_o=1; char_o is stable until the handshake.
  - On char_ready_i: clear acc and len. If remaining==0 go to DONE, else go to SHIFT.
  - char_valid_o drops in the cycle after the handshake.
- DONE: done_de_o=1, held until the next start_i or reset.
- ERR: err_o=1, done_de_o=0, held until the next start_i or reset. No further bits are accepted.
- busy_o=1 in SHIFT, CHECK and EMIT.
- Throughput:
  - Minimum 2 cycles per bit.
  - A character appears 1 cycle after its last bit is accepted (SHIFT->CHECK->EMIT).
  - Back-to-back codewords require no idle beyond the EMIT handshake.
- Remaining count never underflows; bits are not accepted once it is 0.

Test Plan:
- Load A=0x41 (len1, 0), B=0x42 (len2, 10), C=0x43 (len2, 11); start total=6; bits 0,1,0,0,1,1 -> chars 0x41,0x42,0x41,0x43 in order; done_de_o=1; err_o=0.
- Same stream with char_ready_i low for 5 cycles at each EMIT -> char_o stable, bit_ready_o=0 while stalled, same 4 chars, done_de_o=1.
- Table as above minus C; bits 1,1 with total=2 -> CHECK miss at len2, remaining 0 -> err_o=1, no character emitted for those bits.
- Stream ending mid-code: total=1, bit 1 -> err_o=1, done_de_o=0. Separately, 8 unmatched bits with MAX_LEN=8 -> err_o after the 8th bit.
- start_i with total_bit_i=0 -> done_de_o=1 within 2 cycles, no char_valid_o. tbl_we_i during busy -> table unchanged; verified by a subsequent decode.
- Assert rst_i mid-decode (in EMIT) -> all outputs 0 asynchronously, table cleared. Decode after reload is correct.
